// File: rtl/adc_spi_responder.sv
// Slave-side model of a dual serial ADC: two active-low chip selects, shared SCLK, one SDA line.
// Returns a 10-bit sample MSB-first in a 16-clock frame and reports frame counts and protocol errors.
module adc_spi_responder #(
  parameter int FRAME_BITS = 16,
  parameter int LEAD_ZEROS = 3,
  parameter int DATA_BITS  = 10
) (
  input  logic                 i_clk_50m,
  input  logic                 i_rst,
  input  logic                 i_adc_sclk,
  input  logic                 i_adc_cs1,
  input  logic                 i_adc_cs2,
  output logic                 o_adc_sda,
  input  logic [DATA_BITS-1:0] i_ch1_value,
  input  logic [DATA_BITS-1:0] i_ch2_value,
  output logic                 o_frame_done,
  output logic                 o_frame_ch,
  output logic [1:0]           o_err_code,
  output logic [15:0]          o_ch1_cnt,
  output logic [15:0]          o_ch2_cnt
);

  localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_BITS;
  localparam int CNT_W       = $clog2(FRAME_BITS + 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    OVER     = 2'd2,
    CONFLICT = 2'd3
  } state_t;

  state_t                state_r;
  logic [FRAME_BITS-1:0] shreg_r;
  logic [CNT_W-1:0]      rise_cnt_r;
  logic                  ch_r;
  logic                  sda_r;
  logic                  frame_done_r;
  logic                  frame_ch_r;
  logic [1:0]            err_r;
  logic [15:0]           ch1_cnt_r;
  logic [15:0]           ch2_cnt_r;

  logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic cs1_meta_r, cs1_sync_r, cs1_prev_r;
  logic cs2_meta_r, cs2_sync_r, cs2_prev_r;

  logic             sclk_rise_s, sclk_fall_s;
  logic             cs1_fall_s, cs1_rise_s, cs2_fall_s, cs2_rise_s;
  logic             act_cs_rise_s, other_cs_fall_s;
  logic [CNT_W-1:0] rise_cnt_nxt_s;

  // Two-flop synchronizers plus one edge-detect stage; reset loads the idle pin levels
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      sclk_meta_r <= 1'b0; sclk_sync_r <= 1'b0; sclk_prev_r <= 1'b0;
      cs1_meta_r  <= 1'b1; cs1_sync_r  <= 1'b1; cs1_prev_r  <= 1'b1;
      cs2_meta_r  <= 1'b1; cs2_sync_r  <= 1'b1; cs2_prev_r  <= 1'b1;
    end else begin
      sclk_meta_r <= i_adc_sclk; sclk_sync_r <= sclk_meta_r; sclk_prev_r <= sclk_sync_r;
      cs1_meta_r  <= i_adc_cs1;  cs1_sync_r  <= cs1_meta_r;  cs1_prev_r  <= cs1_sync_r;
      cs2_meta_r  <= i_adc_cs2;  cs2_sync_r  <= cs2_meta_r;  cs2_prev_r  <= cs2_sync_r;
    end
  end

  assign sclk_rise_s     = sclk_sync_r & ~sclk_prev_r;
  assign sclk_fall_s     = ~sclk_sync_r & sclk_prev_r;
  assign cs1_fall_s      = ~cs1_sync_r & cs1_prev_r;
  assign cs1_rise_s      = cs1_sync_r & ~cs1_prev_r;
  assign cs2_fall_s      = ~cs2_sync_r & cs2_prev_r;
  assign cs2_rise_s      = cs2_sync_r & ~cs2_prev_r;
  assign act_cs_rise_s   = ch_r ? cs2_rise_s : cs1_rise_s;
  assign other_cs_fall_s = ch_r ? cs1_fall_s : cs2_fall_s;
  // A rise coinciding with the closing CS edge is counted before the length check
  assign rise_cnt_nxt_s  = rise_cnt_r + {{(CNT_W-1){1'b0}}, sclk_rise_s};

  // Frame FSM; SDA is updated together with the shift register so it always mirrors its MSB
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state_r      <= IDLE;
      shreg_r      <= '0;
      rise_cnt_r   <= '0;
      ch_r         <= 1'b0;
      sda_r        <= 1'b0;
      frame_done_r <= 1'b0;
      frame_ch_r   <= 1'b0;
      err_r        <= 2'd0;
      ch1_cnt_r    <= 16'd0;
      ch2_cnt_r    <= 16'd0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          sda_r <= 1'b0;
          if (!cs1_sync_r && !cs2_sync_r) begin
            err_r   <= 2'd3;
            state_r <= CONFLICT;
          end else if (cs1_fall_s) begin
            shreg_r    <= {{LEAD_ZEROS{1'b0}}, i_ch1_value, {TRAIL_ZEROS{1'b0}}};
            ch_r       <= 1'b0;
            rise_cnt_r <= '0;
            state_r    <= SHIFT;
          end else if (cs2_fall_s) begin
            shreg_r    <= {{LEAD_ZEROS{1'b0}}, i_ch2_value, {TRAIL_ZEROS{1'b0}}};
            ch_r       <= 1'b1;
            rise_cnt_r <= '0;
            state_r    <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (other_cs_fall_s) begin
            sda_r   <= 1'b0;
            err_r   <= 2'd3;
            state_r <= CONFLICT;
          end else if (act_cs_rise_s) begin
            sda_r   <= 1'b0;
            state_r <= IDLE;
            if (rise_cnt_nxt_s == CNT_W'(FRAME_BITS)) begin
              frame_done_r <= 1'b1;
              frame_ch_r   <= ch_r;
              if (ch_r) ch2_cnt_r <= ch2_cnt_r + 16'd1;
              else      ch1_cnt_r <= ch1_cnt_r + 16'd1;
            end else if (rise_cnt_nxt_s > CNT_W'(FRAME_BITS)) begin
              err_r <= 2'd2;
            end else begin
              err_r <= 2'd1;
            end
          end else if (sclk_rise_s) begin
            if (rise_cnt_r == CNT_W'(FRAME_BITS)) begin
              sda_r   <= 1'b0;
              err_r   <= 2'd2;
              state_r <= OVER;
            end else begin
              rise_cnt_r <= rise_cnt_nxt_s;
            end
          end else if (sclk_fall_s) begin
            shreg_r <= {shreg_r[FRAME_BITS-2:0], 1'b0};
            sda_r   <= shreg_r[FRAME_BITS-2];
          end else begin
            sda_r <= shreg_r[FRAME_BITS-1];
          end
        end
        OVER: begin
          sda_r <= 1'b0;
          if (act_cs_rise_s) state_r <= IDLE;
          else               state_r <= OVER;
        end
        CONFLICT: begin
          sda_r <= 1'b0;
          if (cs1_sync_r && cs2_sync_r) state_r <= IDLE;
          else                          state_r <= CONFLICT;
        end
        default: begin
          sda_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign o_adc_sda    = sda_r;
  assign o_frame_done = frame_done_r;
  assign o_frame_ch   = frame_ch_r;
  assign o_err_code   = err_r;
  assign o_ch1_cnt    = ch1_cnt_r;
  assign o_ch2_cnt    = ch2_cnt_r;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: drives SPI master frames and checks data, counts and errors.
module tb_adc_spi_responder;

  logic        i_clk_50m = 1'b0;
  logic        i_rst;
  logic        i_adc_sclk;
  logic        i_adc_cs1;
  logic        i_adc_cs2;
  logic        o_adc_sda;
  logic [9:0]  i_ch1_value;
  logic [9:0]  i_ch2_value;
  logic        o_frame_done;
  logic        o_frame_ch;
  logic [1:0]  o_err_code;
  logic [15:0] o_ch1_cnt;
  logic [15:0] o_ch2_cnt;

  int          checks = 0;
  int          passed = 0;
  int          done_seen = 0;
  int          done_base;
  logic        last_ch = 1'b0;
  logic [15:0] cap;

  adc_spi_responder dut (
    .i_clk_50m   (i_clk_50m),
    .i_rst       (i_rst),
    .i_adc_sclk  (i_adc_sclk),
    .i_adc_cs1   (i_adc_cs1),
    .i_adc_cs2   (i_adc_cs2),
    .o_adc_sda   (o_adc_sda),
    .i_ch1_value (i_ch1_value),
    .i_ch2_value (i_ch2_value),
    .o_frame_done(o_frame_done),
    .o_frame_ch  (o_frame_ch),
    .o_err_code  (o_err_code),
    .o_ch1_cnt   (o_ch1_cnt),
    .o_ch2_cnt   (o_ch2_cnt)
  );

  always #10 i_clk_50m = ~i_clk_50m;

  // Records every done pulse and the channel it reported
  always @(negedge i_clk_50m) begin
    if (o_frame_done === 1'b1) begin
      done_seen <= done_seen + 1;
      last_ch   <= o_frame_ch;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk_50m);
  endtask

  task automatic cs_drive(input logic ch, input logic lvl);
    if (ch) i_adc_cs2 = lvl;
    else    i_adc_cs1 = lvl;
  endtask

  // Master samples SDA at each SCLK rise; each phase lasts 8 system clocks
  task automatic clk_bits(input int n);
    for (int i = 0; i < n; i++) begin
      i_adc_sclk = 1'b1;
      cap = {cap[14:0], o_adc_sda};
      tick(8);
      i_adc_sclk = 1'b0;
      tick(8);
    end
  endtask

  task automatic frame(input logic ch, input int n);
    cap = 16'h0000;
    cs_drive(ch, 1'b0);
    tick(8);
    clk_bits(n);
    cs_drive(ch, 1'b1);
    tick(8);
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    i_adc_sclk = 1'b0;
    i_adc_cs1 = 1'b1;
    i_adc_cs2 = 1'b1;
    tick(3);
    i_rst = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_adc_sclk = 1'b0;
    i_adc_cs1 = 1'b1;
    i_adc_cs2 = 1'b1;
    i_ch1_value = 10'h000;
    i_ch2_value = 10'h000;
    tick(3);
    checks++; if (o_adc_sda !== 1'b0) $display("FAIL reset_sda: got %b expected 0", o_adc_sda); else passed++;
    checks++; if (o_frame_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", o_frame_done); else passed++;
    checks++; if (o_frame_ch !== 1'b0) $display("FAIL reset_ch: got %b expected 0", o_frame_ch); else passed++;
    checks++; if (o_err_code !== 2'd0) $display("FAIL reset_err: got %0d expected 0", o_err_code); else passed++;
    checks++; if (o_ch1_cnt !== 16'd0) $display("FAIL reset_cnt1: got %0d expected 0", o_ch1_cnt); else passed++;
    checks++; if (o_ch2_cnt !== 16'd0) $display("FAIL reset_cnt2: got %0d expected 0", o_ch2_cnt); else passed++;
    i_rst = 1'b0;
    tick(4);
  endtask

  task automatic test_good_ch1();
    apply_reset();
    done_base = done_seen;
    i_ch1_value = 10'h2A5;
    frame(1'b0, 16);
    checks++; if (cap !== 16'h1528) $display("FAIL good_data: got %h expected 1528", cap); else passed++;
    checks++; if (done_seen - done_base !== 1) $display("FAIL good_done: got %0d pulses expected 1", done_seen - done_base); else passed++;
    checks++; if (last_ch !== 1'b0) $display("FAIL good_ch: got %b expected 0", last_ch); else passed++;
    checks++; if (o_ch1_cnt !== 16'd1) $display("FAIL good_cnt1: got %0d expected 1", o_ch1_cnt); else passed++;
    checks++; if (o_err_code !== 2'd0) $display("FAIL good_err: got %0d expected 0", o_err_code); else passed++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    done_base = done_seen;
    i_ch2_value = 10'h3FF;
    i_ch1_value = 10'h001;
    frame(1'b1, 16);
    checks++; if (cap !== 16'h1FF8) $display("FAIL b2b_data_ch2: got %h expected 1ff8", cap); else passed++;
    checks++; if (last_ch !== 1'b1) $display("FAIL b2b_ch_first: got %b expected 1", last_ch); else passed++;
    frame(1'b0, 16);
    checks++; if (cap !== 16'h0008) $display("FAIL b2b_data_ch1: got %h expected 0008", cap); else passed++;
    checks++; if (last_ch !== 1'b0) $display("FAIL b2b_ch_second: got %b expected 0", last_ch); else passed++;
    checks++; if (o_ch2_cnt !== 16'd1) $display("FAIL b2b_cnt2: got %0d expected 1", o_ch2_cnt); else passed++;
    checks++; if (o_ch1_cnt !== 16'd1) $display("FAIL b2b_cnt1: got %0d expected 1", o_ch1_cnt); else passed++;
    checks++; if (done_seen - done_base !== 2) $display("FAIL b2b_done: got %0d pulses expected 2", done_seen - done_base); else passed++;
  endtask

  task automatic test_short_frame();
    apply_reset();
    done_base = done_seen;
    i_ch1_value = 10'h2A5;
    frame(1'b0, 12);
    checks++; if (done_seen - done_base !== 0) $display("FAIL short_done: got %0d pulses expected 0", done_seen - done_base); else passed++;
    checks++; if (o_ch1_cnt !== 16'd0) $display("FAIL short_cnt1: got %0d expected 0", o_ch1_cnt); else passed++;
    checks++; if (o_err_code !== 2'd1) $display("FAIL short_err: got %0d expected 1", o_err_code); else passed++;
    frame(1'b0, 16);
    checks++; if (cap !== 16'h1528) $display("FAIL short_next_data: got %h expected 1528", cap); else passed++;
    checks++; if (o_ch1_cnt !== 16'd1) $display("FAIL short_next_cnt1: got %0d expected 1", o_ch1_cnt); else passed++;
    checks++; if (o_err_code !== 2'd1) $display("FAIL short_sticky_err: got %0d expected 1", o_err_code); else passed++;
  endtask

  task automatic test_long_frame();
    apply_reset();
    done_base = done_seen;
    i_ch2_value = 10'h2A5;
    cap = 16'h0000;
    cs_drive(1'b1, 1'b0);
    tick(8);
    clk_bits(16);
    checks++; if (cap !== 16'h1528) $display("FAIL long_data: got %h expected 1528", cap); else passed++;
    checks++; if (o_err_code !== 2'd0) $display("FAIL long_err_before: got %0d expected 0", o_err_code); else passed++;
    clk_bits(1);
    checks++; if (o_adc_sda !== 1'b0) $display("FAIL long_sda: got %b expected 0", o_adc_sda); else passed++;
    checks++; if (o_err_code !== 2'd2) $display("FAIL long_err: got %0d expected 2", o_err_code); else passed++;
    cs_drive(1'b1, 1'b1);
    tick(8);
    checks++; if (o_ch2_cnt !== 16'd0) $display("FAIL long_cnt2: got %0d expected 0", o_ch2_cnt); else passed++;
    checks++; if (done_seen - done_base !== 0) $display("FAIL long_done: got %0d pulses expected 0", done_seen - done_base); else passed++;
  endtask

  task automatic test_conflict();
    apply_reset();
    done_base = done_seen;
    i_ch1_value = 10'h3FF;
    i_ch2_value = 10'h0F0;
    cap = 16'h0000;
    i_adc_cs1 = 1'b0;
    tick(8);
    clk_bits(5);
    checks++; if (o_adc_sda !== 1'b1) $display("FAIL conflict_sda_before: got %b expected 1", o_adc_sda); else passed++;
    i_adc_cs2 = 1'b0;
    tick(5);
    checks++; if (o_adc_sda !== 1'b0) $display("FAIL conflict_sda: got %b expected 0", o_adc_sda); else passed++;
    checks++; if (o_err_code !== 2'd3) $display("FAIL conflict_err: got %0d expected 3", o_err_code); else passed++;
    i_adc_cs1 = 1'b1;
    tick(8);
    i_adc_cs2 = 1'b1;
    tick(8);
    checks++; if (done_seen - done_base !== 0) $display("FAIL conflict_done: got %0d pulses expected 0", done_seen - done_base); else passed++;
    checks++; if (o_ch1_cnt !== 16'd0) $display("FAIL conflict_cnt1: got %0d expected 0", o_ch1_cnt); else passed++;
    frame(1'b1, 16);
    checks++; if (cap !== 16'h0780) $display("FAIL conflict_next_data: got %h expected 0780", cap); else passed++;
    checks++; if (o_ch2_cnt !== 16'd1) $display("FAIL conflict_next_cnt2: got %0d expected 1", o_ch2_cnt); else passed++;
  endtask

  task automatic test_value_change();
    apply_reset();
    i_ch1_value = 10'h155;
    cap = 16'h0000;
    i_adc_cs1 = 1'b0;
    tick(8);
    clk_bits(5);
    i_ch1_value = 10'h2AA;
    clk_bits(11);
    i_adc_cs1 = 1'b1;
    tick(8);
    checks++; if (cap !== 16'h0AA8) $display("FAIL value_hold_data: got %h expected 0aa8", cap); else passed++;
    checks++; if (o_ch1_cnt !== 16'd1) $display("FAIL value_hold_cnt1: got %0d expected 1", o_ch1_cnt); else passed++;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    i_ch2_value = 10'h3FF;
    frame(1'b1, 16);
    checks++; if (o_ch2_cnt !== 16'd1) $display("FAIL midrst_pre_cnt2: got %0d expected 1", o_ch2_cnt); else passed++;
    done_base = done_seen;
    cap = 16'h0000;
    i_adc_cs2 = 1'b0;
    tick(8);
    clk_bits(5);
    checks++; if (o_adc_sda !== 1'b1) $display("FAIL midrst_sda_before: got %b expected 1", o_adc_sda); else passed++;
    i_rst = 1'b1;
    tick(1);
    checks++; if (o_adc_sda !== 1'b0) $display("FAIL midrst_sda: got %b expected 0", o_adc_sda); else passed++;
    checks++; if (o_ch2_cnt !== 16'd0) $display("FAIL midrst_cnt2: got %0d expected 0", o_ch2_cnt); else passed++;
    i_adc_cs2 = 1'b1;
    i_adc_sclk = 1'b0;
    tick(3);
    i_rst = 1'b0;
    tick(8);
    checks++; if (done_seen - done_base !== 0) $display("FAIL midrst_done: got %0d pulses expected 0", done_seen - done_base); else passed++;
    checks++; if (o_err_code !== 2'd0) $display("FAIL midrst_err: got %0d expected 0", o_err_code); else passed++;
    checks++; if (o_ch1_cnt !== 16'd0) $display("FAIL midrst_cnt1: got %0d expected 0", o_ch1_cnt); else passed++;
    checks++; if (o_adc_sda !== 1'b0) $display("FAIL midrst_sda_after: got %b expected 0", o_adc_sda); else passed++;
  endtask

  initial begin
    i_rst = 1'b1;
    i_adc_sclk = 1'b0;
    i_adc_cs1 = 1'b1;
    i_adc_cs2 = 1'b1;
    i_ch1_value = 10'h000;
    i_ch2_value = 10'h000;
    test_reset();
    test_good_ch1();
    test_back_to_back();
    test_short_frame();
    test_long_frame();
    test_conflict();
    test_value_change();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
